// File: rtl/mem_data_initiator.sv
// Data-side initiator for the unified 1024x16 memory: valid/ready request in, strobed access out.
// Define MEM_INIT_READBACK_EN to follow every write with a verify read that sets the sticky wrErr flag.
module mem_data_initiator #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 16,
    parameter int STROBE_CYCLES = 2    // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAdd,
    input  logic [DATA_W-1:0] reqData,
    output logic              rspValid,
    output logic [DATA_W-1:0] rspData,
    output logic              wrErr,
    output logic [ADDR_W-1:0] dataAdd,
    output logic [DATA_W-1:0] writeData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd5;
`ifdef MEM_INIT_READBACK_EN
    localparam logic [2:0] S_CHECK_SETUP  = 3'd3;
    localparam logic [2:0] S_CHECK_STROBE = 3'd4;
    localparam logic [2:0] S_WRITE_DONE   = S_CHECK_SETUP;
`else
    localparam logic [2:0] S_WRITE_DONE   = S_RESP;
`endif

    // Counter holds the number of strobe cycles still to go after the current one.
    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              rsp_q, rsp_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        add_d      = add_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (reqValid && ready_q) begin
                    is_write_d = reqWrite;
                    add_d      = reqAdd;
                    wdata_d    = reqData;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!is_write_q) begin
                    rdata_d = data;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WRITE_DONE;
                end
            end
`ifdef MEM_INIT_READBACK_EN
            S_CHECK_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_CHECK_STROBE;
            end
            S_CHECK_STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Handshake and strobe outputs are registered, decoded from the next state.
        ready_d = (state_d == S_IDLE);
        rsp_d   = (state_d == S_RESP);
        wr_d    = (state_d == S_STROBE) && is_write_d;
        rd_d    = (state_d == S_STROBE) && !is_write_d;
`ifdef MEM_INIT_READBACK_EN
        rd_d    = rd_d || (state_d == S_CHECK_STROBE);
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            // NOTE: all registers, including address/data holding registers, are cleared so outputs read 0 in reset.
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            add_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            rsp_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            add_q      <= add_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            rsp_q      <= rsp_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

`ifdef MEM_INIT_READBACK_EN
    logic err_q, err_d;

    // Compare on the last verify-strobe cycle; the flag stays set until reset.
    always_comb begin
        err_d = err_q;
        if (state_q == S_CHECK_STROBE && cnt_q == 4'd0 && data != wdata_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wrErr = err_q;
`else
    assign wrErr = 1'b0;
`endif

    assign reqReady  = ready_q;
    assign rspValid  = rsp_q;
    assign rspData   = rdata_q;
    assign dataAdd   = add_q;
    assign writeData = wdata_q;
    assign memRead   = rd_q;
    assign memWrite  = wr_q;

endmodule

// File: tb/tb_mem_data_initiator.sv
// Directed bench for mem_data_initiator: vector table plus reset, back-to-back, read-back and strobe-width sequences.
`timescale 1ns/1ps
module tb_mem_data_initiator;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int SC = 2;
`ifdef MEM_INIT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int RSP_RD = 2 + SC;
    localparam int RSP_WR = RB ? 3 + 2 * SC : 2 + SC;
    localparam logic [DW-1:0] SW_MEM = 16'hC3C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_write;
    logic [AW-1:0] req_add;
    logic [DW-1:0] req_data;
    logic          req_ready, rsp_valid, wr_err, mem_read, mem_write;
    logic [DW-1:0] rsp_data, write_data;
    logic [AW-1:0] data_add;
    logic [DW-1:0] mem_data = '0;

    mem_data_initiator #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .reqValid(req_valid), .reqReady(req_ready), .reqWrite(req_write),
        .reqAdd(req_add), .reqData(req_data),
        .rspValid(rsp_valid), .rspData(rsp_data), .wrErr(wr_err),
        .dataAdd(data_add), .writeData(write_data),
        .memRead(mem_read), .memWrite(mem_write), .data(mem_data)
    );

    // Strobe-width sweep instances: index 0 has STROBE_CYCLES=1, index 1 has 15.
    logic          sw_valid [2];
    logic          sw_ready [2], sw_rsp [2], sw_err [2], sw_rd [2], sw_wr [2];
    logic [DW-1:0] sw_rdata [2], sw_wdata [2];
    logic [AW-1:0] sw_add   [2];

    mem_data_initiator #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(1)) u_sc1 (
        .clk(clk), .rst(rst),
        .reqValid(sw_valid[0]), .reqReady(sw_ready[0]), .reqWrite(1'b0),
        .reqAdd(10'd7), .reqData(16'h0000),
        .rspValid(sw_rsp[0]), .rspData(sw_rdata[0]), .wrErr(sw_err[0]),
        .dataAdd(sw_add[0]), .writeData(sw_wdata[0]),
        .memRead(sw_rd[0]), .memWrite(sw_wr[0]), .data(SW_MEM)
    );

    mem_data_initiator #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(15)) u_sc15 (
        .clk(clk), .rst(rst),
        .reqValid(sw_valid[1]), .reqReady(sw_ready[1]), .reqWrite(1'b0),
        .reqAdd(10'd9), .reqData(16'h0000),
        .rspValid(sw_rsp[1]), .rspData(sw_rdata[1]), .wrErr(sw_err[1]),
        .dataAdd(sw_add[1]), .writeData(sw_wdata[1]),
        .memRead(sw_rd[1]), .memWrite(sw_wr[1]), .data(SW_MEM)
    );

    // Memory model: acts on strobe rising edges; the write to address 5 is corrupted to 0.
    logic [DW-1:0] mem     [0:1023];
    bit            written [0:1023];

    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        case (a)
            10'd1:   return 16'h7FFF;
            10'd2:   return 16'h2222;
            10'd3:   return 16'h8002;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge mem_write) begin
        mem[data_add]     = (data_add == 10'd5) ? 16'h0000 : write_data;
        written[data_add] = 1'b1;
    end

    always @(posedge mem_read) begin
        mem_data = written[data_add] ? mem[data_add] : preload(data_add);
    end

    bit overlap_seen = 1'b0;
    always @(negedge clk) begin
        if ((mem_read && mem_write) || (sw_rd[0] && sw_wr[0]) || (sw_rd[1] && sw_wr[1])) overlap_seen = 1'b1;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_applied = 0;
    int n_miscmp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    // One complete transaction with latency, strobe-width, hold and response checks.
    task automatic do_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata, input logic exp_err);
        int  cyc, rsp_cyc, rd_n, wr_n, first_strobe;
        bit  hold_ok;
        req_valid = 1'b1;
        req_write = wr;
        req_add   = addr;
        req_data  = wdata;
        wait_ready();
        check({name, " accept"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_add   = ~addr;
        req_data  = ~wdata;
        cyc = 1; rsp_cyc = 0; rd_n = 0; wr_n = 0; first_strobe = 0; hold_ok = 1'b1;
        while (cyc <= 40) begin
            if (mem_read) rd_n++;
            if (mem_write) wr_n++;
            if ((mem_read || mem_write) && first_strobe == 0) first_strobe = cyc;
            if (data_add !== addr || (wr && write_data !== wdata)) hold_ok = 1'b0;
            if (rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " rsp_cycle"}, rsp_cyc, wr ? RSP_WR : RSP_RD);
        check({name, " first_strobe"}, first_strobe, 2);
        check({name, " memRead_len"}, rd_n, wr ? (RB ? SC : 0) : SC);
        check({name, " memWrite_len"}, wr_n, wr ? SC : 0);
        check({name, " addr_data_hold"}, hold_ok, 1);
        check({name, " rspData"}, rsp_data, exp_rdata);
        check({name, " wrErr"}, wr_err, exp_err);
        @(posedge clk); #1;
        check({name, " rsp_pulse_end"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic back_to_back();
        int acc [3];
        int pulses, t;
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 16'h0001; exp_d[1] = 16'h7FFF; exp_d[2] = 16'h2222;
        pulses = 0;
        req_write = 1'b0;
        req_add   = 10'd0;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready();
            @(posedge clk); #1;
            acc[k] = cyc_cnt;
            req_add = AW'(k + 1);
            check($sformatf("b2b%0d addr_cycle1", k), data_add, k);
            t = 0;
            while (!rsp_valid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (rsp_valid) pulses++;
            check($sformatf("b2b%0d rspData", k), rsp_data, exp_d[k]);
            check($sformatf("b2b%0d addr_at_resp", k), data_add, k);
            if (k > 0) check($sformatf("b2b%0d spacing", k), acc[k] - acc[k-1], 3 + SC);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("b2b rsp_pulses", pulses, 3);
    endtask

    task automatic reset_mid_strobe();
        bit stray;
        req_write = 1'b0;
        req_add   = 10'd3;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstmid strobe_up", mem_read, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rstmid outputs_low", {mem_read, mem_write, rsp_valid, req_ready}, 4'b0000);
        check("rstmid rspData_cleared", rsp_data, 16'h0000);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid ready_after_release", req_ready, 1);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || mem_read || mem_write) stray = 1'b1;
            @(posedge clk); #1;
        end
        check("rstmid no_stray_activity", stray, 0);
        do_txn("rstmid read3", 1'b0, 10'd3, 16'h0000, 16'h8002, 1'b0);
    endtask

    task automatic sweep(input int idx, input int sc);
        int t, cyc, rsp_cyc, rd_n;
        sw_valid[idx] = 1'b1;
        t = 0;
        while (!sw_ready[idx] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        sw_valid[idx] = 1'b0;
        cyc = 1; rsp_cyc = 0; rd_n = 0;
        while (cyc <= 40) begin
            if (sw_rd[idx]) rd_n++;
            if (sw_rsp[idx]) begin
                rsp_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("sweep%0d rsp_cycle", sc), rsp_cyc, 2 + sc);
        check($sformatf("sweep%0d strobe_len", sc), rd_n, sc);
        check($sformatf("sweep%0d rspData", sc), sw_rdata[idx], SW_MEM);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Writes expect rspData to still hold the previous read value.
        vecs[0] = '{1'b0, 10'd3,    16'h0000, 16'h8002};
        vecs[1] = '{1'b1, 10'd1023, 16'hBEEF, 16'h8002};
        vecs[2] = '{1'b0, 10'd1023, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 10'd0,    16'h0001, 16'hBEEF};
        vecs[4] = '{1'b0, 10'd0,    16'h0000, 16'h0001};
        vecs[5] = '{1'b0, 10'd1,    16'h0000, 16'h7FFF};
        vecs[6] = '{1'b1, 10'd512,  16'hA5A5, 16'h7FFF};
        vecs[7] = '{1'b0, 10'd512,  16'h0000, 16'hA5A5};

        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_add = '0; req_data = '0;
        sw_valid[0] = 1'b0; sw_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctrl_outputs", {req_ready, rsp_valid, wr_err, mem_read, mem_write}, 5'b00000);
        check("reset rspData", rsp_data, 16'h0000);
        check("reset addr_wdata", {data_add, write_data}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset ready_after_release", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
        end

        back_to_back();
        reset_mid_strobe();

        do_txn("bad write5",  1'b1, 10'd5, 16'h1234, 16'h8002, RB);
        do_txn("good write6", 1'b1, 10'd6, 16'h5555, 16'h8002, RB);
        do_txn("read6",       1'b0, 10'd6, 16'h0000, 16'h5555, RB);
        do_txn("read5",       1'b0, 10'd5, 16'h0000, 16'h0000, RB);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("wrErr cleared_by_reset", wr_err, 0);

        sweep(0, 1);
        sweep(1, 15);
        check("strobe overlap", overlap_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
